debug_mailbox: RTL and testbench

//  Memory-mapped debug mailbox on the data-memory bus, replacing the bare debug RAM.
//  The core writes argument words 1..NARGS-1, then the function word (index 0).
//  The function-word write snapshots all words into a message and raises a valid/ready doorbell.
//  The consumer (bench checker, or later a host serial bridge) drains messages one at a time.
//  A new doorbell while a message is pending stalls the core; no message is ever dropped.

---
 rtl/dbg_pkg.sv | 27 ++
 rtl/debug_mailbox.sv | 59 +++++
 tb/tb_debug_mailbox.sv | 120 ++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// dbg_pkg: shared debug mailbox function codes, message type and byte-merge helper
// Holds the default mailbox geometry, the codes the consumer decodes from word 0,
// and the byte-enable merge used on every mailbox write.
package dbg_pkg;
  localparam int DBG_NARGS = 8;
  localparam int DBG_DW = 32;
  localparam logic [31:0] DBG_EXIT = 32'd0;
  localparam logic [31:0] DBG_ASSERT_EQ = 32'd1;
  localparam logic [31:0] DBG_ASSERT_NE = 32'd2;
  localparam logic [31:0] DBG_PUTS4 = 32'd3;
  localparam logic [31:0] DBG_REGCHK = 32'h0001_0000;
  localparam logic [31:0] DBG_DUMP = 32'hFFFF_0000;
  localparam logic [31:0] REGCHK_IGNORE_GPSP = 32'h0001_0000;
  typedef logic [DBG_NARGS-1:0][DBG_DW-1:0] dbg_msg_t;
  typedef enum logic {S_IDLE, S_FULL} mbox_state_t;
  function automatic logic [DBG_DW-1:0] byte_merge(
    input logic [DBG_DW-1:0] old_w,
    input logic [DBG_DW-1:0] new_w,
    input logic [DBG_DW/8-1:0] be
  );
    logic [DBG_DW-1:0] m;
    m = old_w;
    for (int b = 0; b < DBG_DW/8; b++)
      if (be[b]) m[b*8 +: 8] = new_w[b*8 +: 8];
    return m;
  endfunction
endpackage

// File: rtl/debug_mailbox.sv
// debug_mailbox: bus-mapped mailbox that snapshots argument words into a message on a word-0 write
// Ports: clk/reset (async, active-high); we/addr/be/wdata core write, rdata live read;
// stall holds a doorbell write while a message is pending; dbg_valid/dbg_ready/dbg_msg/dbg_seq
// present the pending message to the consumer.
module debug_mailbox
  import dbg_pkg::*;
#(
  parameter int NARGS = DBG_NARGS,
  parameter int DW = DBG_DW,
  parameter int SEQ_W = 16,
  localparam int AW = $clog2(NARGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [DW/8-1:0]     be,
  input  logic [DW-1:0]       wdata,
  output logic [DW-1:0]       rdata,
  output logic                stall,
  output logic                dbg_valid,
  input  logic                dbg_ready,
  output logic [NARGS*DW-1:0] dbg_msg,
  output logic [SEQ_W-1:0]    dbg_seq
);
  logic [DW-1:0] r_live [NARGS];
  logic [NARGS-1:0][DW-1:0] r_shadow;
  logic [SEQ_W-1:0] r_seq;
  mbox_state_t r_state;
  logic [DW-1:0] w_merged;
  logic w_acc;
  logic w_bell;
  assign dbg_valid = (r_state == S_FULL);
  // A doorbell may only overwrite the shadow once the pending message retires this cycle.
  assign stall = we & (addr == '0) & dbg_valid & ~dbg_ready;
  assign w_acc = we & ~stall;
  assign w_bell = w_acc & (addr == '0);
  assign w_merged = byte_merge(r_live[addr], wdata, be);
  assign rdata = r_live[addr];
  assign dbg_msg = r_shadow;
  assign dbg_seq = r_seq;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NARGS; i++) r_live[i] <= '0;
      r_shadow <= '0;
      r_seq <= '0;
      r_state <= S_IDLE;
    end else begin
      if (w_acc) r_live[addr] <= w_merged;
      if (w_bell) begin
        // Word 0 takes the value being written this edge; the rest are pre-edge live words.
        for (int i = 1; i < NARGS; i++) r_shadow[i] <= r_live[i];
        r_shadow[0] <= w_merged;
        r_seq <= r_seq + 1'b1;
      end
      r_state <= w_bell ? S_FULL : (dbg_ready ? S_IDLE : r_state);
    end
  end
endmodule

// File: tb/tb_debug_mailbox.sv
// tb_debug_mailbox: table-driven check of the debug mailbox plus wrap and async-reset sequences
module tb_debug_mailbox;
  import dbg_pkg::*;
  logic clk = 0;
  logic reset = 1;
  logic we = 0;
  logic [2:0] addr = 0;
  logic [3:0] be = 0;
  logic [31:0] wdata = 0;
  logic [31:0] rdata;
  logic stall;
  logic dbg_valid;
  logic dbg_ready = 0;
  logic [255:0] dbg_msg;
  logic [15:0] dbg_seq;
  int total = 0;
  int bad = 0;
  debug_mailbox dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .be(be), .wdata(wdata),
    .rdata(rdata), .stall(stall), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
    .dbg_msg(dbg_msg), .dbg_seq(dbg_seq)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic we; logic [2:0] a; logic [3:0] be; logic [31:0] d; logic rdy;
    logic st; logic [31:0] rd;
    logic v; logic [15:0] sq; logic [31:0] w0; logic [31:0] w1; logic [31:0] w2;
  } vec_t;
  vec_t tv [15];
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic w, input logic [2:0] a, input logic [3:0] b, input logic [31:0] d, input logic r);
    we = w; addr = a; be = b; wdata = d; dbg_ready = r;
  endtask
  initial begin
    tv[0]  = '{1, 1, 4'hF, 5, 0,  0, 0,  0, 0, 0, 0, 0};
    tv[1]  = '{1, 2, 4'hF, 5, 0,  0, 0,  0, 0, 0, 0, 0};
    tv[2]  = '{1, 0, 4'hF, DBG_ASSERT_EQ, 0,  0, 0,  1, 1, DBG_ASSERT_EQ, 5, 5};
    tv[3]  = '{1, 0, 4'hF, DBG_EXIT, 0,  1, 1,  1, 1, 1, 5, 5};
    tv[4]  = '{1, 0, 4'hF, DBG_EXIT, 0,  1, 1,  1, 1, 1, 5, 5};
    tv[5]  = '{1, 0, 4'hF, DBG_EXIT, 1,  0, 1,  1, 2, DBG_EXIT, 5, 5};
    tv[6]  = '{1, 1, 4'hF, 7, 0,  0, 5,  1, 2, 0, 5, 5};
    tv[7]  = '{0, 1, 4'h0, 0, 0,  0, 7,  1, 2, 0, 5, 5};
    tv[8]  = '{0, 1, 4'h0, 0, 1,  0, 7,  0, 2, 0, 5, 5};
    tv[9]  = '{1, 0, 4'hF, DBG_DUMP, 0,  0, 0,  1, 3, 32'hFFFF0000, 7, 5};
    tv[10] = '{0, 0, 4'h0, 0, 1,  0, 32'hFFFF0000,  0, 3, 32'hFFFF0000, 7, 5};
    tv[11] = '{1, 0, 4'h1, 32'hAABBCC03, 0,  0, 32'hFFFF0000,  1, 4, 32'hFFFF0003, 7, 5};
    tv[12] = '{0, 0, 4'h0, 0, 1,  0, 32'hFFFF0003,  0, 4, 32'hFFFF0003, 7, 5};
    tv[13] = '{0, 0, 4'h0, 0, 1,  0, 32'hFFFF0003,  0, 4, 32'hFFFF0003, 7, 5};
    tv[14] = '{1, 2, 4'hF, 9, 1,  0, 5,  0, 4, 32'hFFFF0003, 7, 5};
    #1;
    chk("reset_valid", dbg_valid, 0);
    chk("reset_seq", dbg_seq, 0);
    chk("reset_msg", dbg_msg, 0);
    chk("reset_stall", stall, 0);
    chk("reset_rdata", rdata, 0);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tv[i].we, tv[i].a, tv[i].be, tv[i].d, tv[i].rdy);
      #1;
      chk($sformatf("v%0d_stall", i), stall, tv[i].st);
      chk($sformatf("v%0d_rdata", i), rdata, tv[i].rd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), dbg_valid, tv[i].v);
      chk($sformatf("v%0d_seq", i), dbg_seq, tv[i].sq);
      chk($sformatf("v%0d_w0", i), dbg_msg[0 +: 32], tv[i].w0);
      chk($sformatf("v%0d_w1", i), dbg_msg[32 +: 32], tv[i].w1);
      chk($sformatf("v%0d_w2", i), dbg_msg[64 +: 32], tv[i].w2);
    end
    // back-to-back doorbells with ready held high: one increment per cycle up to 0xFFFF
    @(negedge clk);
    drive(1, 0, 4'hF, 32'h0, 1);
    repeat (16'hFFFF - 4) @(posedge clk);
    @(negedge clk);
    drive(0, 0, 4'h0, 32'h0, 0);
    chk("wrap_pre_seq", dbg_seq, 16'hFFFF);
    chk("wrap_pre_valid", dbg_valid, 1);
    drive(1, 0, 4'hF, DBG_PUTS4, 1);
    @(posedge clk);
    #1;
    chk("wrap_seq", dbg_seq, 16'h0000);
    chk("wrap_valid", dbg_valid, 1);
    chk("wrap_w0", dbg_msg[0 +: 32], DBG_PUTS4);
    // asynchronous reset in the middle of a cycle while a message is pending
    @(negedge clk);
    drive(1, 0, 4'hF, 32'h55, 0);
    #1;
    chk("pre_rst_stall", stall, 1);
    #1;
    reset = 1;
    #1;
    chk("arst_valid", dbg_valid, 0);
    chk("arst_seq", dbg_seq, 0);
    chk("arst_msg", dbg_msg, 0);
    chk("arst_stall", stall, 0);
    addr = 1;
    #1;
    chk("arst_rdata1", rdata, 0);
    @(negedge clk);
    reset = 0;
    drive(1, 0, 4'hF, DBG_REGCHK, 0);
    @(posedge clk);
    #1;
    chk("post_rst_seq", dbg_seq, 1);
    chk("post_rst_valid", dbg_valid, 1);
    chk("post_rst_msg", dbg_msg, {224'h0, DBG_REGCHK});
    @(negedge clk);
    drive(0, 0, 4'h0, 32'h0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
